// File: rtl/mem_stage_pkg.sv
// Shared pipeline definitions for the memory stage and the MEM/WB register.
package mem_stage_pkg;

   // Writeback result select encodings
   localparam logic [1:0] RES_ALU  = 2'd0;
   localparam logic [1:0] RES_LOAD = 2'd1;
   localparam logic [1:0] RES_PC4  = 2'd2;
   localparam logic [1:0] RES_IMM  = 2'd3;

   // Load/store funct3 encodings
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic {
      ST_IDLE,
      ST_WAIT
   } mem_state_e;

   typedef struct packed {
      logic       valid;
      logic       RegWrite;
      logic [1:0] ResultSrc;
      logic [4:0] Rd;
   } memwb_ctrl_t;

   typedef struct packed {
      logic [31:0] ALUResult;
      logic [31:0] load_data;
      logic [31:0] PCPlus4;
      logic [31:0] ImmExt;
   } memwb_data_t;

   // Everything that must stay stable while a request is outstanding
   typedef struct packed {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [2:0]  funct3;
      logic [1:0]  lo;
   } dmem_req_t;

   // Byte accesses are always aligned; halves need addr[0]=0; words need addr[1:0]=0
   function automatic logic is_aligned(input logic [2:0] funct3, input logic [1:0] lo);
      logic ok;
      case (funct3[1:0])
         2'b00:   ok = 1'b1;
         2'b01:   ok = ~lo[0];
         default: ok = (lo == 2'b00);
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/mem_stage_load_extend.sv
// Selects the addressed byte/half of a read word and sign/zero-extends it.
module load_extend
   import mem_stage_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] rdata_i,
   output logic [31:0] data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Lane selection and extension by load type
   always_comb begin
      case (addr_lo_i)
         2'd0:    byte_sel = rdata_i[7:0];
         2'd1:    byte_sel = rdata_i[15:8];
         2'd2:    byte_sel = rdata_i[23:16];
         default: byte_sel = rdata_i[31:24];
      endcase
      half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
      case (funct3_i)
         F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
         F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
         F3_W:    data_o = rdata_i;
         F3_BU:   data_o = {24'd0, byte_sel};
         F3_HU:   data_o = {16'd0, half_sel};
         default: data_o = '0;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory stage: data-memory handshake, store lane steering, load
// extension and the writing side of the MEM/WB pipeline register.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ex_valid,
   input  logic            ex_RegWrite,
   input  logic [1:0]      ex_ResultSrc,
   input  logic            ex_MemRead,
   input  logic            ex_MemWrite,
   input  logic [2:0]      ex_funct3,
   input  logic [XLEN-1:0] ex_ALUResult,
   input  logic [XLEN-1:0] ex_WriteData,
   input  logic [XLEN-1:0] ex_PCPlus4,
   input  logic [XLEN-1:0] ex_ImmExt,
   input  logic [4:0]      ex_Rd,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [XLEN-1:0] dmem_addr,
   output logic [XLEN-1:0] dmem_wdata,
   output logic [3:0]      dmem_be,
   input  logic            dmem_ready,
   input  logic [XLEN-1:0] dmem_rdata,
   output logic            stall_mem,
   output logic            misaligned,
   output logic            wb_valid,
   output logic            wb_RegWrite,
   output logic [1:0]      wb_ResultSrc,
   output logic [XLEN-1:0] wb_ALUResult,
   output logic [XLEN-1:0] wb_load_data,
   output logic [XLEN-1:0] wb_PCPlus4,
   output logic [XLEN-1:0] wb_ImmExt,
   output logic [4:0]      wb_Rd
);

   if (XLEN != 32) begin : g_xlen_check
      $error("mem_stage supports XLEN=32 only");
   end

   mem_state_e  state_q, state_d;
   dmem_req_t   req_now, req_q, req_sel;
   memwb_ctrl_t wb_ctrl_q, wb_ctrl_d;
   memwb_data_t wb_data_q, wb_data_d;
   logic        mis_q, mis_d;
   logic        is_mem, acc, mis_access;
   logic        req_raw, stall_raw, complete;
   logic [31:0] ext_data;

   assign is_mem     = ex_MemRead | ex_MemWrite;
   assign acc        = ex_valid & is_mem & is_aligned(ex_funct3, ex_ALUResult[1:0]);
   assign mis_access = ex_valid & is_mem & ~is_aligned(ex_funct3, ex_ALUResult[1:0]);

   // Build the request from EX/MEM; a load wins if both MemRead and MemWrite are set
   always_comb begin
      req_now.addr   = {ex_ALUResult[31:2], 2'b00};
      req_now.we     = ex_MemWrite & ~ex_MemRead;
      req_now.funct3 = ex_funct3;
      req_now.lo     = ex_ALUResult[1:0];
      req_now.be     = 4'b1111;
      req_now.wdata  = ex_WriteData;
      if (req_now.we) begin
         case (ex_funct3[1:0])
            2'b00: begin
               req_now.be    = 4'b0001 << ex_ALUResult[1:0];
               req_now.wdata = {4{ex_WriteData[7:0]}};
            end
            2'b01: begin
               req_now.be    = ex_ALUResult[1] ? 4'b1100 : 4'b0011;
               req_now.wdata = {2{ex_WriteData[15:0]}};
            end
            default: ;
         endcase
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // FSM next state: wait only while an accepted access has no ready
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (acc && !dmem_ready) state_d = ST_WAIT;
         ST_WAIT: if (dmem_ready)         state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM outputs; request and stall are forced low while reset is asserted
   always_comb begin
      req_sel   = (state_q == ST_WAIT) ? req_q : req_now;
      req_raw   = (state_q == ST_WAIT) ? 1'b1 : acc;
      stall_raw = req_raw & ~dmem_ready;
      complete  = req_raw & dmem_ready;
   end

   assign dmem_req   = rst_n & req_raw;
   assign stall_mem  = rst_n & stall_raw;
   assign dmem_we    = req_sel.we;
   assign dmem_addr  = req_sel.addr;
   assign dmem_be    = req_sel.be;
   assign dmem_wdata = req_sel.wdata;

   // Freeze the request fields when an access is accepted in IDLE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                             req_q <= '0;
      else if (state_q == ST_IDLE && acc)     req_q <= req_now;
   end

   load_extend u_load_extend (
      .funct3_i  (req_sel.funct3),
      .addr_lo_i (req_sel.lo),
      .rdata_i   (dmem_rdata),
      .data_o    (ext_data)
   );

   // MEM/WB next value: bubble on stall or empty slot, else capture EX/MEM
   always_comb begin
      wb_ctrl_d          = wb_ctrl_q;
      wb_ctrl_d.valid    = 1'b0;
      wb_ctrl_d.RegWrite = 1'b0;
      wb_data_d          = wb_data_q;
      mis_d              = 1'b0;
      if (!stall_raw && ex_valid) begin
         wb_ctrl_d.valid     = 1'b1;
         wb_ctrl_d.RegWrite  = ex_RegWrite & ~mis_access;
         wb_ctrl_d.ResultSrc = ex_ResultSrc;
         wb_ctrl_d.Rd        = ex_Rd;
         wb_data_d.ALUResult = ex_ALUResult;
         wb_data_d.load_data = (complete && !req_sel.we) ? ext_data : '0;
         wb_data_d.PCPlus4   = ex_PCPlus4;
         wb_data_d.ImmExt    = ex_ImmExt;
         mis_d               = mis_access;
      end
   end

   // MEM/WB register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_ctrl_q <= '0;
         wb_data_q <= '0;
         mis_q     <= 1'b0;
      end else begin
         wb_ctrl_q <= wb_ctrl_d;
         wb_data_q <= wb_data_d;
         mis_q     <= mis_d;
      end
   end

   assign wb_valid     = wb_ctrl_q.valid;
   assign wb_RegWrite  = wb_ctrl_q.RegWrite;
   assign wb_ResultSrc = wb_ctrl_q.ResultSrc;
   assign wb_Rd        = wb_ctrl_q.Rd;
   assign wb_ALUResult = wb_data_q.ALUResult;
   assign wb_load_data = wb_data_q.load_data;
   assign wb_PCPlus4   = wb_data_q.PCPlus4;
   assign wb_ImmExt    = wb_data_q.ImmExt;
   assign misaligned   = mis_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed stimulus pushes expected MEM/WB
// entries; a monitor pops and compares whenever wb_valid is seen.
module tb_mem_stage;
   import mem_stage_pkg::*;

   logic        clk, rst_n;
   logic        ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite;
   logic [1:0]  ex_ResultSrc;
   logic [2:0]  ex_funct3;
   logic [31:0] ex_ALUResult, ex_WriteData, ex_PCPlus4, ex_ImmExt;
   logic [4:0]  ex_Rd;
   logic        dmem_req, dmem_we, dmem_ready;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_be;
   logic        stall_mem, misaligned;
   logic        wb_valid, wb_RegWrite;
   logic [1:0]  wb_ResultSrc;
   logic [31:0] wb_ALUResult, wb_load_data, wb_PCPlus4, wb_ImmExt;
   logic [4:0]  wb_Rd;

   mem_stage #(.XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .ex_valid(ex_valid), .ex_RegWrite(ex_RegWrite), .ex_ResultSrc(ex_ResultSrc),
      .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite), .ex_funct3(ex_funct3),
      .ex_ALUResult(ex_ALUResult), .ex_WriteData(ex_WriteData),
      .ex_PCPlus4(ex_PCPlus4), .ex_ImmExt(ex_ImmExt), .ex_Rd(ex_Rd),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ready(dmem_ready),
      .dmem_rdata(dmem_rdata), .stall_mem(stall_mem), .misaligned(misaligned),
      .wb_valid(wb_valid), .wb_RegWrite(wb_RegWrite), .wb_ResultSrc(wb_ResultSrc),
      .wb_ALUResult(wb_ALUResult), .wb_load_data(wb_load_data),
      .wb_PCPlus4(wb_PCPlus4), .wb_ImmExt(wb_ImmExt), .wb_Rd(wb_Rd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        mis;
      logic        full;
      logic        rw;
      logic [1:0]  src;
      logic [31:0] alu;
      logic [31:0] ld;
      logic [4:0]  rd;
   } exp_t;

   exp_t sb[$];
   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] pc4_of(input logic [31:0] a);
      return 32'h1000_0004 + a;
   endfunction

   function automatic logic [31:0] imm_of(input logic [31:0] a);
      return a ^ 32'h5A5A_0000;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_ex();
      ex_valid = 1'b0; ex_RegWrite = 1'b0; ex_MemRead = 1'b0; ex_MemWrite = 1'b0;
   endtask

   task automatic drive(input logic rw, input logic [1:0] src, input logic mr, input logic mw,
                        input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] wd,
                        input logic [4:0] rd);
      ex_valid = 1'b1; ex_RegWrite = rw; ex_ResultSrc = src; ex_MemRead = mr;
      ex_MemWrite = mw; ex_funct3 = f3; ex_ALUResult = alu; ex_WriteData = wd;
      ex_PCPlus4 = pc4_of(alu); ex_ImmExt = imm_of(alu); ex_Rd = rd;
   endtask

   task automatic push(input logic mis, input logic full, input logic rw, input logic [1:0] src,
                       input logic [31:0] alu, input logic [31:0] ld, input logic [4:0] rd);
      exp_t e;
      e.mis = mis; e.full = full; e.rw = rw; e.src = src; e.alu = alu; e.ld = ld; e.rd = rd;
      sb.push_back(e);
   endtask

   // Monitor: compare every MEM/WB entry against the scoreboard head
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (wb_valid) begin
               if (sb.size() == 0) begin
                  check("wb_unexpected", 32'd1, 32'd0);
               end else begin
                  e = sb.pop_front();
                  check("wb_RegWrite", {31'd0, wb_RegWrite}, {31'd0, e.rw});
                  check("misaligned", {31'd0, misaligned}, {31'd0, e.mis});
                  if (e.full) begin
                     check("wb_ResultSrc", {30'd0, wb_ResultSrc}, {30'd0, e.src});
                     check("wb_ALUResult", wb_ALUResult, e.alu);
                     check("wb_load_data", wb_load_data, e.ld);
                     check("wb_PCPlus4", wb_PCPlus4, pc4_of(e.alu));
                     check("wb_ImmExt", wb_ImmExt, imm_of(e.alu));
                     check("wb_Rd", {27'd0, wb_Rd}, {27'd0, e.rd});
                  end
               end
            end else begin
               check("bubble_RegWrite", {31'd0, wb_RegWrite}, 32'd0);
               check("bubble_misaligned", {31'd0, misaligned}, 32'd0);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      idle_ex();
      ex_ResultSrc = RES_ALU; ex_funct3 = F3_W; ex_ALUResult = '0; ex_WriteData = '0;
      ex_PCPlus4 = '0; ex_ImmExt = '0; ex_Rd = '0;
      dmem_ready = 1'b0; dmem_rdata = '0;

      // Reset: an accepted-looking LW must not raise req/stall, wb cleared
      drive(1'b1, RES_LOAD, 1'b1, 1'b0, F3_W, 32'h40, 32'h0, 5'd3);
      #3;
      check("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
      check("rst_stall", {31'd0, stall_mem}, 32'd0);
      check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
      check("rst_wb_ALUResult", wb_ALUResult, 32'd0);
      check("rst_misaligned", {31'd0, misaligned}, 32'd0);
      idle_ex();
      step();
      step();
      rst_n = 1'b1;
      step();

      // ALU op
      drive(1'b1, RES_ALU, 1'b0, 1'b0, F3_W, 32'h0000_1234, 32'h0, 5'd5);
      push(1'b0, 1'b1, 1'b1, RES_ALU, 32'h0000_1234, 32'h0, 5'd5);
      @(negedge clk);
      check("alu_dmem_req", {31'd0, dmem_req}, 32'd0);
      check("alu_stall", {31'd0, stall_mem}, 32'd0);
      step();

      // Zero-wait byte/half loads from 0x80FF_7F01
      dmem_ready = 1'b1; dmem_rdata = 32'h80FF_7F01;
      drive(1'b1, RES_LOAD, 1'b1, 1'b0, F3_B, 32'h103, 32'h0, 5'd6);
      push(1'b0, 1'b1, 1'b1, RES_LOAD, 32'h103, 32'hFFFF_FF80, 5'd6);
      @(negedge clk);
      check("lb_req", {31'd0, dmem_req}, 32'd1);
      check("lb_addr", dmem_addr, 32'h100);
      check("lb_we", {31'd0, dmem_we}, 32'd0);
      check("lb_be", {28'd0, dmem_be}, 32'hF);
      check("lb_stall", {31'd0, stall_mem}, 32'd0);
      step();
      drive(1'b1, RES_LOAD, 1'b1, 1'b0, F3_BU, 32'h103, 32'h0, 5'd7);
      push(1'b0, 1'b1, 1'b1, RES_LOAD, 32'h103, 32'h0000_0080, 5'd7);
      step();
      drive(1'b1, RES_LOAD, 1'b1, 1'b0, F3_H, 32'h102, 32'h0, 5'd8);
      push(1'b0, 1'b1, 1'b1, RES_LOAD, 32'h102, 32'hFFFF_80FF, 5'd8);
      step();
      drive(1'b1, RES_LOAD, 1'b1, 1'b0, F3_HU, 32'h100, 32'h0, 5'd9);
      push(1'b0, 1'b1, 1'b1, RES_LOAD, 32'h100, 32'h0000_7F01, 5'd9);
      step();

      // SH with three wait cycles
      dmem_ready = 1'b0;
      drive(1'b0, RES_ALU, 1'b0, 1'b1, F3_H, 32'h202, 32'hDEAD_BEEF, 5'd0);
      push(1'b0, 1'b1, 1'b0, RES_ALU, 32'h202, 32'h0, 5'd0);
      for (int i = 0; i < 4; i++) begin
         if (i == 3) dmem_ready = 1'b1;
         @(negedge clk);
         check("sh_req", {31'd0, dmem_req}, 32'd1);
         check("sh_we", {31'd0, dmem_we}, 32'd1);
         check("sh_addr", dmem_addr, 32'h200);
         check("sh_be", {28'd0, dmem_be}, 32'hC);
         check("sh_wdata", dmem_wdata, 32'hBEEF_BEEF);
         check("sh_stall", {31'd0, stall_mem}, (i < 3) ? 32'd1 : 32'd0);
         if (i > 0) check("sh_bubble", {31'd0, wb_valid}, 32'd0);
         step();
      end

      // SB lane steering
      drive(1'b0, RES_ALU, 1'b0, 1'b1, F3_B, 32'h201, 32'h1122_3344, 5'd0);
      push(1'b0, 1'b1, 1'b0, RES_ALU, 32'h201, 32'h0, 5'd0);
      @(negedge clk);
      check("sb_be", {28'd0, dmem_be}, 32'h2);
      check("sb_wdata", dmem_wdata, 32'h4444_4444);
      step();

      // Misaligned LW
      drive(1'b1, RES_LOAD, 1'b1, 1'b0, F3_W, 32'h305, 32'h0, 5'd9);
      push(1'b1, 1'b0, 1'b0, RES_LOAD, 32'h305, 32'h0, 5'd9);
      @(negedge clk);
      check("mis_dmem_req", {31'd0, dmem_req}, 32'd0);
      check("mis_stall", {31'd0, stall_mem}, 32'd0);
      step();
      idle_ex();
      step();

      // Reset while waiting: request abandoned, nothing reaches MEM/WB
      dmem_ready = 1'b0;
      drive(1'b1, RES_LOAD, 1'b1, 1'b0, F3_W, 32'h400, 32'h0, 5'd10);
      @(negedge clk);
      check("wait_stall0", {31'd0, stall_mem}, 32'd1);
      step();
      @(negedge clk);
      check("wait_stall1", {31'd0, stall_mem}, 32'd1);
      check("wait_req", {31'd0, dmem_req}, 32'd1);
      check("wait_addr", dmem_addr, 32'h400);
      #2;
      rst_n = 1'b0;
      #1;
      check("rstw_req", {31'd0, dmem_req}, 32'd0);
      check("rstw_stall", {31'd0, stall_mem}, 32'd0);
      check("rstw_wb_valid", {31'd0, wb_valid}, 32'd0);
      check("rstw_wb_Rd", {27'd0, wb_Rd}, 32'd0);
      check("rstw_wb_PCPlus4", wb_PCPlus4, 32'd0);
      idle_ex();
      step();
      step();
      rst_n = 1'b1;
      step();
      dmem_ready = 1'b1; dmem_rdata = 32'h1234_5678;
      drive(1'b1, RES_LOAD, 1'b1, 1'b0, F3_W, 32'h8, 32'h0, 5'd11);
      push(1'b0, 1'b1, 1'b1, RES_LOAD, 32'h8, 32'h1234_5678, 5'd11);
      step();

      // Back-to-back zero-wait loads, then a PC+4 writeback
      dmem_rdata = 32'hAAAA_5555;
      drive(1'b1, RES_LOAD, 1'b1, 1'b0, F3_W, 32'h0, 32'h0, 5'd12);
      push(1'b0, 1'b1, 1'b1, RES_LOAD, 32'h0, 32'hAAAA_5555, 5'd12);
      @(negedge clk);
      check("b2b0_stall", {31'd0, stall_mem}, 32'd0);
      step();
      dmem_rdata = 32'h0000_CAFE;
      drive(1'b1, RES_LOAD, 1'b1, 1'b0, F3_W, 32'h4, 32'h0, 5'd13);
      push(1'b0, 1'b1, 1'b1, RES_LOAD, 32'h4, 32'h0000_CAFE, 5'd13);
      @(negedge clk);
      check("b2b1_stall", {31'd0, stall_mem}, 32'd0);
      check("b2b0_wb_valid", {31'd0, wb_valid}, 32'd1);
      step();
      drive(1'b1, RES_PC4, 1'b0, 1'b0, F3_W, 32'h0000_0ABC, 32'h0, 5'd1);
      push(1'b0, 1'b1, 1'b1, RES_PC4, 32'h0000_0ABC, 32'h0, 5'd1);
      @(negedge clk);
      check("b2b1_wb_valid", {31'd0, wb_valid}, 32'd1);
      step();
      idle_ex();
      repeat (4) step();
      check("sb_drained", sb.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the RV32I five-stage pipeline. It is the writing end of the MEM/WB pipeline register that the writeback stage reads.
- Takes EX/MEM control and data, performs load/store accesses on a ready-handshaked data-memory port, and sign/zero-extends load data.
- Registers all writeback fields (ALUResult, load_data, PCPlus4, ImmExt, Rd, RegWrite, ResultSrc) into MEM/WB.
- Stalls the upstream pipeline while a data-memory access is outstanding.

Parameters:
XLEN, 32, datapath width (fixed at 32 for RV32I; asserted at elaboration)

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
ex_valid  input  1  EX/MEM holds a real instruction
ex_RegWrite  input  1  instruction writes rd
ex_ResultSrc  input  2  writeback select: 0 ALU, 1 load, 2 PC+4, 3 ImmExt
ex_MemRead  input  1  load instruction
ex_MemWrite  input  1  store instruction
ex_funct3  input  3  load/store size and sign (LB/LH/LW/LBU/LHU, SB/SH/SW)
ex_ALUResult  input  32  effective address or ALU result
ex_WriteData  input  32  store data (rs2)
ex_PCPlus4  input  32  PC+4
ex_ImmExt  input  32  extended immediate
ex_Rd  input  5  destination register
dmem_req  output  1  access request
dmem_we  output  1  1 = write
dmem_addr  output  32  word-aligned address (bits[1:0] = 0)
dmem_wdata  output  32  lane-shifted store data
dmem_be  output  4  byte enables
dmem_ready  input  1  access completes this cycle
dmem_rdata  input  32  read word, valid when dmem_ready=1
stall_mem  output  1  hold IF/ID/EX and EX/MEM this cycle
misaligned  output  1  one-cycle pulse: misaligned access suppressed
wb_valid, wb_RegWrite  output  1 each  MEM/WB control
wb_ResultSrc  output  2  MEM/WB control
wb_ALUResult, wb_load_data, wb_PCPlus4, wb_ImmExt  output  32 each  MEM/WB data
wb_Rd  output  5  MEM/WB destination

Behaviour:
- Reset (async assert, sync release): FSM=IDLE; all wb_* = 0; misaligned = 0. dmem_req and stall_mem read 0 while rst_n=0.
- Access condition: acc = ex_valid & (ex_MemRead | ex_MemWrite) & aligned.
  - Aligned: word requires addr[1:0]==0; half requires addr[0]==0; byte is always aligned.
  - MemRead and MemWrite both 1 is illegal; treat it as a load.
- FSM IDLE:
  - dmem_req = acc, driven combinationally from ex_*.
  - acc & dmem_ready: complete in the same cycle (zero-wait); stay in IDLE.
  - acc & !dmem_ready: stall_mem = 1; go to WAIT.
- FSM WAIT:
  - dmem_req = 1, with dmem_addr/we/be/wdata driven from registered copies captured on entry. Upstream is held, so the registered copies equal ex_*.
  - stall_mem = !dmem_ready.
  - dmem_ready: complete; return to IDLE.
- Request fields must not change while dmem_req=1 and dmem_ready=0.
- Store lanes:
  - SB: be = 1 << addr[1:0]; wdata = {4{rs2[7:0]}}.
  - SH: be = 0011 or 1100 by addr[1]; wdata = {2{rs2[15:0]}}.
  - SW: be = 1111.
  - Loads: be = 1111, we = 0.
- Load extract: select the byte/half of dmem_rdata by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW takes the full word. Unknown funct3 → load_data = 0.
- MEM/WB register update, every cycle:
  - Stall cycle: bubble (wb_valid=0, wb_RegWrite=0; other fields don't-care, hold previous).
  - Completing access or non-memory ex_valid: capture all fields, load_data = extracted value (0 for non-loads), wb_valid=1.
  - ex_valid=0: bubble.
- Misaligned: no dmem_req; capture as a bubble-equivalent with wb_valid=1, wb_RegWrite=0; misaligned=1 for that cycle only; no stall.
- Latency: non-memory ops take 1 cycle to wb_*. A memory op takes 1 + wait cycles. A ready in the same cycle as the request is 1 cycle.
- Reset mid-WAIT: the request is abandoned and dmem_req drops immediately. The memory must tolerate an abandoned request.

Decomposition:
- Shared pipeline package holds:
  - ResultSrc encodings: RES_ALU=0, RES_LOAD=1, RES_PC4=2, RES_IMM=3.
  - funct3 constants: F3_B/H/W/BU/HU.
  - memwb_ctrl_t / memwb_data_t structs, which the memwb_if payload reuses.
- One sub-module, load_extend: combinational funct3 + addr[1:0] + rdata → 32-bit extended value; unit-testable alone.

Test Plan:
- ALU op, ex_ALUResult=0x0000_1234, Rd=5, RegWrite=1 → next cycle wb_valid=1, wb_ALUResult=0x1234, wb_Rd=5, stall_mem=0, dmem_req=0.
- LB addr 0x103, dmem_rdata=0x80FF_7F01, ready same cycle → dmem_addr=0x100, wb_load_data=0xFFFF_FF80; LBU gives 0x0000_0080.
- SH addr 0x202, rs2=0xDEAD_BEEF, ready after 3 cycles → dmem_be=1100, wdata=0xBEEF_BEEF held stable; stall_mem high for 3 cycles; 3 bubbles then one valid wb entry.
- LW addr 0x305 → misaligned pulse 1 cycle, dmem_req=0, wb_valid=1 with wb_RegWrite=0.
- rst_n low during WAIT → dmem_req and stall_mem drop immediately; wb_* = 0; after release a new LW completes normally.
- Back-to-back zero-wait loads at 0x0, 0x4 → two consecutive valid wb entries, no stall cycles.
